// File: rtl/game_timer_pkg.sv
// Shared types and BCD helpers for the game round countdown timer.
package game_timer_pkg;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    function automatic bcd2_t bcd_clamp(input logic [7:0] raw);
        bcd2_t r;
        r = raw;
        if (r.tens > 4'd9) r.tens = 4'd9;
        if (r.ones > 4'd9) r.ones = 4'd9;
        return r;
    endfunction

    // Floors at 00 so a stray call on an empty count cannot wrap.
    function automatic bcd2_t bcd_dec(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones != 4'd0) begin
            r.ones = v.ones - 4'd1;
        end else if (v.tens != 4'd0) begin
            r.tens = v.tens - 4'd1;
            r.ones = 4'd9;
        end
        return r;
    endfunction

    function automatic bcd2_t bcd_add_sat(input bcd2_t v, input logic [3:0] n);
        logic [7:0] bin;
        bcd2_t      r;
        bin = {4'd0, v.tens} * 8'd10 + {4'd0, v.ones} + {4'd0, n};
        if (bin > 8'd99) begin
            r = BCD_MAX;
        end else begin
            r.tens = 4'(bin / 8'd10);
            r.ones = 4'(bin % 8'd10);
        end
        return r;
    endfunction

endpackage

// File: rtl/game_countdown_timer_sec_prescaler.sv
// Divides clk down to a one-cycle second tick; holds while en is low.
module sec_prescaler #(
    parameter int unsigned TICK_DIV = 31_500_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned   W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/game_countdown_timer.sv
// BCD 00-99 seconds countdown with registered digits and a terminal-count level.
// Optional bonus-seconds input is built only when TIMER_BONUS_EN is defined.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 31_500_000,
    parameter int unsigned BONUS_SEC = 5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic [7:0] startValue,
    input  logic       enable,
`ifdef TIMER_BONUS_EN
    input  logic       bonusAdd,
`endif
    output logic [3:0] tensDigit,
    output logic [3:0] onesDigit,
    output logic       running,
    output logic       tc
);

    localparam logic [3:0] BONUS_DIGIT = 4'(BONUS_SEC);

    timer_state_t state_q, state_d;
    bcd2_t        count_q, count_d;
    logic         running_q, running_d;
    logic         tc_q, tc_d;
    logic         presc_en;
    logic         tick;
    logic         bonus_w;
    bcd2_t        loaded;
    bcd2_t        stepped;

`ifdef TIMER_BONUS_EN
    assign bonus_w = bonusAdd;
`else
    // Tied off so the add/saturate path folds away entirely.
    assign bonus_w = 1'b0;
`endif

    assign presc_en = (state_q == RUN) && enable;

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .resetN (resetN),
        .clr    (load),
        .en     (presc_en),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        loaded  = bcd_clamp(startValue);
        stepped = count_q;

        if (load) begin
            count_d = loaded;
            state_d = (loaded == 8'h00) ? DONE : RUN;
        end else if (state_q == RUN) begin
            // Tick and bonus combine: decrement first, then add with saturation.
            if (tick)    stepped = bcd_dec(count_q);
            if (bonus_w) stepped = bcd_add_sat(stepped, BONUS_DIGIT);
            count_d = stepped;
            if (stepped == 8'h00) state_d = DONE;
        end

        running_d = (state_d == RUN);
        tc_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= running_d;
            tc_q      <= tc_d;
        end
    end

    assign tensDigit = count_q.tens;
    assign onesDigit = count_q.ones;
    assign running   = running_q;
    assign tc        = tc_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer; bonus scenarios need TIMER_BONUS_EN.
module tb_game_countdown_timer;

    localparam int unsigned TD = 4;
    localparam int unsigned BS = 5;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       load = 1'b0;
    logic [7:0] startValue = 8'h00;
    logic       enable = 1'b0;
`ifdef TIMER_BONUS_EN
    logic       bonusAdd = 1'b0;
`endif
    logic [3:0] tensDigit;
    logic [3:0] onesDigit;
    logic       running;
    logic       tc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic [7:0] cnt;
        logic       run;
        logic       tc;
    } exp_t;

    exp_t sb[$];

    game_countdown_timer #(
        .TICK_DIV  (TD),
        .BONUS_SEC (BS)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .load       (load),
        .startValue (startValue),
        .enable     (enable),
`ifdef TIMER_BONUS_EN
        .bonusAdd   (bonusAdd),
`endif
        .tensDigit  (tensDigit),
        .onesDigit  (onesDigit),
        .running    (running),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        resetN = 1'b0;
        step(2);
        for (int unsigned c = 0; c < 4; c++) begin
            sb.push_back('{$sformatf("reset c%0d", c), 8'h00, 1'b0, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            if (c == 1) begin
                #3 resetN = 1'b1;
                enable = 1'b1;
                step(1);
            end else begin
                step(1);
            end
        end
    endtask

    task automatic test_countdown();
        exp_t e;
        enable = 1'b1;
        startValue = 8'h03;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 32; c++) begin
            logic [7:0] x;
            x = (c < 12) ? 8'(3 - c / 4) : 8'h00;
            sb.push_back('{$sformatf("countdown c%0d", c), x, c < 12, c >= 12});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            step(1);
        end
    endtask

    task automatic test_borrow();
        exp_t e;
        startValue = 8'h10;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 4; c++) begin
            sb.push_back('{$sformatf("borrow c%0d", c), (c < 4) ? 8'h10 : 8'h09, 1'b1, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            step(1);
        end
    endtask

    task automatic test_enable_pause();
        exp_t e;
        enable = 1'b1;
        startValue = 8'h05;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 14; c++) begin
            sb.push_back('{$sformatf("pause c%0d", c), (c < 14) ? 8'h05 : 8'h04, 1'b1, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            enable = (c < 2) || (c >= 12);
            step(1);
        end
        enable = 1'b1;
    endtask

    task automatic test_load_on_tick();
        exp_t e;
        startValue = 8'h05;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 8; c++) begin
            logic [7:0] x;
            x = (c <= 3) ? 8'h05 : (c < 8) ? 8'h02 : 8'h01;
            sb.push_back('{$sformatf("load_on_tick c%0d", c), x, 1'b1, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            load = (c == 3);
            startValue = (c == 3) ? 8'h02 : 8'h05;
            step(1);
        end
        load = 1'b0;
    endtask

    task automatic test_zero_and_clamp();
        exp_t e;
        startValue = 8'h00;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 5; c++) begin
            sb.push_back('{$sformatf("zero_load c%0d", c), 8'h00, 1'b0, 1'b1});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            step(1);
        end
        startValue = 8'hAF;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 4; c++) begin
            sb.push_back('{$sformatf("clamp c%0d", c), (c < 4) ? 8'h99 : 8'h98, 1'b1, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            step(1);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        startValue = 8'h01;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 9; c++) begin
            logic [7:0] x;
            x = (c < 4) ? 8'h01 : (c == 4) ? 8'h00 : (c < 9) ? 8'h02 : 8'h01;
            sb.push_back('{$sformatf("back_to_back c%0d", c), x, c != 4, c == 4});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            load = (c == 4);
            startValue = (c == 4) ? 8'h02 : 8'h01;
            step(1);
        end
        load = 1'b0;
    endtask

`ifdef TIMER_BONUS_EN
    task automatic test_bonus();
        exp_t e;
        startValue = 8'h97;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 4; c++) begin
            logic [7:0] x;
            x = (c == 0) ? 8'h97 : (c < 4) ? 8'h99 : 8'h98;
            sb.push_back('{$sformatf("bonus_sat c%0d", c), x, 1'b1, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            bonusAdd = (c == 0);
            step(1);
        end
        bonusAdd = 1'b0;
        startValue = 8'h03;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 4; c++) begin
            sb.push_back('{$sformatf("bonus_tick c%0d", c), (c < 4) ? 8'h03 : 8'h07, 1'b1, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            bonusAdd = (c == 3);
            step(1);
        end
        bonusAdd = 1'b0;
        startValue = 8'h00;
        load = 1'b1;
        step(1);
        load = 1'b0;
        for (int unsigned c = 0; c <= 3; c++) begin
            sb.push_back('{$sformatf("bonus_done c%0d", c), 8'h00, 1'b0, 1'b1});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
            bonusAdd = (c == 0);
            step(1);
        end
        bonusAdd = 1'b0;
    endtask
`endif

    task automatic test_reset_midcount();
        exp_t e;
        startValue = 8'h42;
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        sb.push_back('{"pre_reset", 8'h42, 1'b1, 1'b0});
        e = sb.pop_front();
        tests++;
        if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
            fails++;
            $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                     e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
        end
        #2 resetN = 1'b0;
        #1;
        sb.push_back('{"async_reset", 8'h00, 1'b0, 1'b0});
        e = sb.pop_front();
        tests++;
        if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
            fails++;
            $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                     e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
        end
        step(2);
        #3 resetN = 1'b1;
        for (int unsigned c = 0; c < 6; c++) begin
            step(1);
            sb.push_back('{$sformatf("post_reset_idle c%0d", c), 8'h00, 1'b0, 1'b0});
            e = sb.pop_front();
            tests++;
            if ({tensDigit, onesDigit} !== e.cnt || running !== e.run || tc !== e.tc) begin
                fails++;
                $display("FAIL %s: got cnt=%h run=%b tc=%b, expected cnt=%h run=%b tc=%b",
                         e.name, {tensDigit, onesDigit}, running, tc, e.cnt, e.run, e.tc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_enable_pause();
        test_load_on_tick();
        test_zero_and_clamp();
        test_back_to_back();
`ifdef TIMER_BONUS_EN
        test_bonus();
`endif
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, run did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Seconds countdown timer for the game round clock: a BCD value of 00–99 seconds counts down once per second from a prescaled `clk`. The count is shown on the VGA score/timer digits. The block drives a terminal-count level `tc`. The downstream end-of-timer edge detector turns `tc` into a single game-over/level-end pulse.

## Interface
- `TICK_DIV`, default 31_500_000: `clk` cycles per second tick; benches use 4.
- `BONUS_SEC`, default 5: seconds added per bonus pulse (0–9).
- `clk` in 1: system clock.
- `resetN` in 1: reset, asynchronous, active-low.
- `load` in 1: one-cycle pulse; loads `startValue` and arms the timer.
- `startValue` in 8: BCD start value, tens in [7:4] and ones in [3:0].
- `enable` in 1: high = count; low = freeze both the prescaler and the count.
- `bonusAdd` in 1: one-cycle pulse; adds `BONUS_SEC`. Present only with TIMER_BONUS_EN.
- `tensDigit` out 4: BCD tens of the current count.
- `onesDigit` out 4: BCD ones of the current count.
- `running` out 1: high in RUN.
- `tc` out 1: terminal count, held high in DONE.

## Operation
- States:
  - IDLE: after reset, count 00, `tc`=0.
  - RUN: counting.
  - DONE: count 00, `tc`=1.
- `load` from any state:
  - Count ← `startValue`. Any digit >9 is clamped to 9.
  - Prescaler ← 0.
  - Next state is RUN if the clamped value is nonzero, otherwise DONE.
- Prescaler:
  - Runs only in RUN with `enable`=1.
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` = prescaler at TICK_DIV-1 while in RUN with `enable`=1.
- On `tick`, the count decrements in BCD:
  - Ones 0 → 9 with tens−1.
  - 01 → 00 moves to DONE.
- `enable` low in RUN holds the prescaler and count exactly. Resuming continues the partial second.
- DONE holds until `load`. Ticks and bonus have no effect in DONE.
- Priority on simultaneous events: `load` > (tick, bonus).
- Tick and bonus in the same cycle: result = count − 1 + BONUS_SEC, saturated at 99. The result never reaches 00, so the state stays RUN.
- Outputs are all registered, with no combinational path from inputs.

## Timing
- Reset values: `tensDigit`=0, `onesDigit`=0, `running`=0, `tc`=0, prescaler 0, state IDLE.
- Reset mid-count aborts immediately to these values.
- `load` at edge N: digits valid and `running`=1 after edge N. For a zero load, `tc`=1 after edge N instead.
- First decrement: TICK_DIV enabled cycles after the `load` edge.
- `tc` rises on the same edge that the digits become 00. It stays high until the edge after a `load`.
- `tc` is a level. The consumer performs edge detection, so `tc` never pulses.

## Configuration
- `TIMER_BONUS_EN` defined:
  - `bonusAdd` port exists.
  - In RUN, each pulse adds BONUS_SEC with saturation at 99 (e.g. 97+5 → 99).
  - In IDLE/DONE the pulse is ignored.
- Undefined: the port is absent and the add/saturate logic is not built.

## Structure
- Shared package `game_timer_pkg`:
  - `bcd2_t` struct (tens, ones 4-bit each).
  - `timer_state_t` enum {IDLE, RUN, DONE}.
  - `BCD_MAX` = 8'h99.
  - Functions `bcd_clamp`, `bcd_dec`, `bcd_add_sat`.
- One sub-module, `sec_prescaler`:
  - Inputs: `clk`, `resetN`, `clr`, `en`.
  - Output: `tick`.
  - Parameter: TICK_DIV.
- FSM and BCD arithmetic live in the top module.

## Test plan
- Reset, then load 8'h03, `enable`=1, TICK_DIV=4:
  - Count 03 → 02 → 01 → 00 at 4-cycle spacing.
  - `tc` rises with 00 and stays high for 20 further cycles.
- Load 8'h10: after one tick the count is 09 (borrow across digits).
- Load 8'h05: drop `enable` at prescaler=2 for 10 cycles, then restore. Expect no change while low, and the decrement 2 enabled cycles after resume.
- `load` 8'h02 on the same edge as a tick in RUN: count 02, prescaler 0, and no decrement on that edge.
- Load 8'h00 and 8'hAF:
  - 00 → DONE with `tc`=1 after one edge.
  - AF → clamped to 99 in RUN.
- TIMER_BONUS_EN, count 97:
  - bonusAdd → 99.
  - At 03, bonusAdd together with a tick → 07.
  - In DONE, bonusAdd leaves 00 and `tc`=1.
- `resetN` low mid-count at 42: all outputs 0 asynchronously, state IDLE.
